// File: rtl/rv32_pc_sequencer_pkg.sv
// Shared rv32 PC-sequencer definitions: FSM state encodings, redirect kinds,
// default vectors and the target alignment helper.
package rv32_pc_sequencer_pkg;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } pcState_e;

   typedef enum logic [2:0] {
      REDIR_SEQ      = 3'd0,
      REDIR_STALL    = 3'd1,
      REDIR_XFER     = 3'd2,
      REDIR_MRET     = 3'd3,
      REDIR_MISALIGN = 3'd4,
      REDIR_TRAP     = 3'd5
   } redirKind_e;

   function automatic logic isMisaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage

// File: rtl/rv32_pc_sequencer_if.sv
// Control/redirect bundle between the pipeline (master) and the PC sequencer (slave).
interface rv32_pc_sequencer_if;
   logic [31:0] pc_i;
   logic        stall_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic        trap_i;
   logic        mret_i;
   logic        halt_i;
   logic [31:0] pc_next_o;
   logic        flush_o;
   logic [31:0] epc_o;
   logic        misaligned_o;
   logic        halted_o;

   modport slave (
      input  pc_i, stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
      input  trap_i, mret_i, halt_i,
      output pc_next_o, flush_o, epc_o, misaligned_o, halted_o
   );

   modport master (
      output pc_i, stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
      output trap_i, mret_i, halt_i,
      input  pc_next_o, flush_o, epc_o, misaligned_o, halted_o
   );
endinterface

// File: rtl/rv32_pc_redirect_sel.sv
// Combinational redirect priority mux and alignment check for the PC sequencer.
module rv32_pc_redirect_sel
   import rv32_pc_sequencer_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        trap_i,
   input  logic        mret_i,
   output redirKind_e  kind_o,
   output logic        xferValid_o,
   output logic [31:0] xferTarget_o,
   output logic [31:0] seqPc_o
);

   // Jump outranks branch when both arrive, so its target is the one checked.
   always_comb begin
      xferValid_o  = jump_i | branch_taken_i;
      xferTarget_o = jump_i ? jump_target_i : branch_target_i;
      seqPc_o      = pc_i + 32'd4;
      kind_o       = REDIR_SEQ;
      if (trap_i)
         kind_o = REDIR_TRAP;
      else if (xferValid_o && isMisaligned(xferTarget_o))
         kind_o = REDIR_MISALIGN;
      else if (mret_i)
         kind_o = REDIR_MRET;
      else if (xferValid_o)
         kind_o = REDIR_XFER;
      else if (stall_i)
         kind_o = REDIR_STALL;
   end

endmodule

// File: rtl/rv32im_pc.sv
// Program counter register; loads the sequencer's next PC every cycle.
module rv32im_pc #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_VECTOR;
      else
         pc_q <= pc_next_i;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/rv32_pc_sequencer.sv
// PC sequencer: BOOT/RUN/HOLD/HALT FSM choosing the next fetch address, with
// a pending-redirect register for stalled jumps/branches and the saved EPC.
module rv32_pc_sequencer
   import rv32_pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
   input  logic               clk,
   input  logic               reset,
   rv32_pc_sequencer_if.slave seq
);

   pcState_e    state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [31:0] epc_q, epc_d;
   redirKind_e  kind;
   logic        xferValid;
   logic [31:0] xferTarget;
   logic [31:0] seqPc;
   logic        takeTrap;

   rv32_pc_redirect_sel u_sel (
      .pc_i            (seq.pc_i),
      .stall_i         (seq.stall_i),
      .branch_taken_i  (seq.branch_taken_i),
      .branch_target_i (seq.branch_target_i),
      .jump_i          (seq.jump_i),
      .jump_target_i   (seq.jump_target_i),
      .trap_i          (seq.trap_i),
      .mret_i          (seq.mret_i),
      .kind_o          (kind),
      .xferValid_o     (xferValid),
      .xferTarget_o    (xferTarget),
      .seqPc_o         (seqPc)
   );

   assign takeTrap = (kind == REDIR_TRAP) || (kind == REDIR_MISALIGN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BOOT;
         pending_q <= 32'd0;
         epc_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         epc_q     <= epc_d;
      end
   end

   // Traps (including misaligned targets) win over everything, stall and halt included.
   always_comb begin
      state_d          = state_q;
      pending_d        = pending_q;
      epc_d            = epc_q;
      seq.pc_next_o    = seq.pc_i;
      seq.flush_o      = 1'b0;
      seq.misaligned_o = 1'b0;
      seq.halted_o     = 1'b0;
      case (state_q)
         BOOT: begin
            seq.pc_next_o = RESET_VECTOR;
            seq.flush_o   = 1'b1;
            state_d       = RUN;
         end
         RUN: begin
            if (takeTrap) begin
               seq.pc_next_o    = TRAP_VECTOR;
               seq.flush_o      = 1'b1;
               seq.misaligned_o = (kind == REDIR_MISALIGN);
               epc_d            = seq.pc_i;
            end else if (seq.halt_i) begin
               state_d   = HALT;
               pending_d = 32'd0;
            end else begin
               case (kind)
                  REDIR_MRET: begin
                     seq.pc_next_o = epc_q;
                     seq.flush_o   = 1'b1;
                  end
                  REDIR_XFER: begin
                     if (seq.stall_i) begin
                        pending_d = xferTarget;
                        state_d   = HOLD;
                     end else begin
                        seq.pc_next_o = xferTarget;
                        seq.flush_o   = 1'b1;
                     end
                  end
                  REDIR_STALL: seq.pc_next_o = seq.pc_i;
                  default:     seq.pc_next_o = seqPc;
               endcase
            end
         end
         HOLD: begin
            if (takeTrap) begin
               seq.pc_next_o    = TRAP_VECTOR;
               seq.flush_o      = 1'b1;
               seq.misaligned_o = (kind == REDIR_MISALIGN);
               epc_d            = seq.pc_i;
               pending_d        = 32'd0;
               state_d          = RUN;
            end else if (seq.halt_i) begin
               state_d   = HALT;
               pending_d = 32'd0;
            end else if (seq.stall_i) begin
               if (xferValid)
                  pending_d = xferTarget;
            end else begin
               seq.pc_next_o = pending_q;
               seq.flush_o   = 1'b1;
               pending_d     = 32'd0;
               state_d       = RUN;
            end
         end
         HALT: seq.halted_o = 1'b1;
         default: state_d = BOOT;
      endcase
      if (reset) begin
         seq.pc_next_o    = RESET_VECTOR;
         seq.flush_o      = 1'b1;
         seq.misaligned_o = 1'b0;
         seq.halted_o     = 1'b0;
      end
   end

   assign seq.epc_o = epc_q;

endmodule
